oled_i2c_arbiter: RTL and testbench
===================================

// Module: oled_i2c_arbiter
// PURPOSE
//  Shares the single i2c_master byte engine between the OLED init/command sequencer (port 0) and the map frame streamer (port 1).
//  Wraps each granted packet as START, addr byte {SLAVE_ADDR,1'b0}, control byte (CTRL_CMD port0 / CTRL_DATA port1), payload bytes, STOP.
//  Sits between the requesters and U_i2c_master inside top_oled_map; reports per-port completion/NACK/timeout.
// PARAMETERS
//  SLAVE_ADDR  7'h3C   OLED 7-bit I2C address
//  CTRL_CMD    8'h00   control byte for port 0 packets (command stream)
//  CTRL_DATA   8'h40   control byte for port 1 packets (GDDRAM data)
//  WDOG_CYC    20000   max clk cycles a byte may wait for mst_ack/mst_nack
// PORTS
//  clk        in   1  system clock
//  reset      in   1  asynchronous, active-high reset
//  rqN_tvalid in   1  (N=0,1) payload byte valid
//  rqN_tdata  in   8  payload byte
//  rqN_tlast  in   1  last payload byte of packet
//  rqN_tready out  1  payload byte consumed this cycle
//  rqN_done   out  1  1-cycle pulse: packet finished with all bytes ACKed
//  rqN_err    out  1  1-cycle pulse: packet finished after NACK or watchdog timeout
//  mst_req    out  1  byte request to i2c_master; held with stable mst_data/first/last until mst_ack|mst_nack
//  mst_data   out  8  byte to transmit
//  mst_first  out  1  master issues START before this byte
//  mst_last   out  1  master issues STOP after this byte's ACK
//  mst_abort  out  1  1-cycle pulse: master drops current byte, issues STOP, returns idle
//  mst_ack    in   1  1-cycle pulse: byte sent, slave ACKed (WAIT_ACK sampled 0)
//  mst_nack   in   1  1-cycle pulse: slave NACKed; master issues STOP itself
//  busy       out  1  state != IDLE
//  owner      out  1  port currently granted (valid while busy)
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; owner=0; watchdog=0; rr pointer=0.
//  States: IDLE -> ADDR -> CTRL -> DATA -> FIN -> IDLE; DRAIN on error.
//  IDLE: any rqN_tvalid -> latch owner (arbitration below), go ADDR next cycle. No tready in IDLE.
//  ADDR: mst_req=1, mst_data={SLAVE_ADDR,0}, mst_first=1. mst_ack -> CTRL; mst_nack -> DRAIN.
//  CTRL: mst_req=1, mst_data=ctrl byte of owner. mst_ack -> DATA; mst_nack -> DRAIN.
//  DATA: mst_req=owner tvalid, mst_data=owner tdata, mst_last=owner tlast (combinational pass-through).
//    owner tready = mst_ack. mst_ack with tlast -> FIN; mst_nack -> DRAIN (nack byte NOT consumed).
//    tvalid low mid-packet: mst_req low, master holds bus (SCL low); not an error; watchdog paused.
//  FIN: owner done pulse 1 cycle -> IDLE. Earliest next grant is the cycle after.
//  DRAIN: mst_req=0; owner tready=1 until tvalid&tlast accepted, then owner err pulse, -> IDLE.
//    Drain of ADDR/CTRL failure includes the whole packet; other port never sees tready.
//  Watchdog: counts cycles with mst_req=1 and no ack/nack; reset on every ack/nack/state change.
//    count==WDOG_CYC-1 -> mst_abort pulse, -> DRAIN. ack/nack same cycle as expiry: ack/nack wins.
//  Never more than one of rq0/rq1 tready high; done and err never both in a packet.
//  Reset mid-packet: everything returns to reset values immediately; master reset by same signal.
// CONFIGURATION
//  OLED_ARB_RR_EN defined: round-robin; on both valid in IDLE grant port != last-served
//    (pointer updated at FIN/DRAIN exit). Undefined: fixed priority, port 0 always wins ties
//    (init/commands starve frame data by design).
// STRUCTURE
//  Shared package oled_i2c_pkg: state encoding, OLED_ADDR, CTRL_CMD/CTRL_DATA constants, i2c_master
//    byte-interface command definitions (also used by i2c_master and sequencers).
//  Sub-module oled_i2c_wdog: loadable down-counter (clear, enable, expire pulse), WDOG_CYC param.
// TESTING  (slave model forces ACK in WAIT_ACK unless told to NACK)
//  rq0 3-byte pkt AE,D5,80 -> mst bytes 78,00,AE,D5,80; first only on 78; last only on 80; rq0_done 1 pulse.
//  rq1 2-byte pkt 12,34 -> bytes 78,40,12,34; rq1_tready 2 pulses aligned to mst_ack; rq1_done.
//  rq0,rq1 valid same cycle -> fixed: rq0 pkt then rq1; RR_EN with last=0: rq1 first, then rq0.
//  NACK on addr byte for rq1 4-byte pkt -> DRAIN accepts 4 bytes, rq1_err 1 pulse, no rq1_done, busy drops.
//  Slave silent (no ack/nack) with WDOG_CYC=50 -> mst_abort at 50th waiting cycle, drain, rq0_err.
//  reset asserted during DATA byte 2 -> all outputs 0 same cycle; new rq0 pkt afterwards completes normally.

Source files
------------

// File: rtl/oled_i2c_pkg.sv
// rtl/oled_i2c_pkg.sv - shared definitions for the OLED I2C arbiter, sequencers and i2c_master
//
// Purpose: arbiter state encoding, OLED bus constants and the i2c_master
//          byte-interface command record shared by every block that talks
//          to the byte engine.
// Ports:   none (package)
package oled_i2c_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ADDR  = 3'd1,
      ST_CTRL  = 3'd2,
      ST_DATA  = 3'd3,
      ST_FIN   = 3'd4,
      ST_DRAIN = 3'd5
   } arb_state_t;

   localparam logic [6:0] OLED_ADDR      = 7'h3C;
   localparam logic [7:0] OLED_CTRL_CMD  = 8'h00;
   localparam logic [7:0] OLED_CTRL_DATA = 8'h40;
   localparam int         OLED_WDOG_CYC  = 20000;

   // One byte request towards i2c_master: held stable until ack/nack.
   typedef struct packed {
      logic       req;
      logic [7:0] data;
      logic       first;
      logic       last;
   } mst_cmd_t;

   localparam mst_cmd_t MST_IDLE = '{req: 1'b0, data: 8'h00, first: 1'b0, last: 1'b0};

   // I2C address byte: 7-bit address followed by the R/W bit.
   function automatic logic [7:0] addr_byte(input logic [6:0] addr, input logic rd);
      return {addr, rd};
   endfunction

endpackage

// File: rtl/oled_i2c_wdog.sv
// rtl/oled_i2c_wdog.sv - loadable down-counter watchdog for the I2C byte handshake
//
// Purpose: counts cycles a byte request waits for ack/nack; expire is high
//          on the WDOG_CYC-th enabled cycle after the last clear.
// Ports:
//   clk     in  system clock
//   reset   in  asynchronous, active-high reset
//   clear   in  reload the counter (new byte / state change)
//   enable  in  a byte is waiting this cycle
//   expire  out waiting budget exhausted this cycle
module oled_i2c_wdog #(
   parameter int WDOG_CYC = 20000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int            CW   = $clog2(WDOG_CYC + 1);
   localparam logic [CW-1:0] LOAD = CW'(WDOG_CYC - 1);

   logic [CW-1:0] count;

   // The first waiting cycle sees LOAD, so count reaches zero on the
   // WDOG_CYC-th waiting cycle. Every entry into a requesting state goes
   // through a clear, so the reset value of zero never fires spuriously.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= LOAD;
      end else if (enable && (count != '0)) begin
         count <= count - CW'(1);
      end
   end

   assign expire = enable && (count == '0);

endmodule

// File: rtl/oled_i2c_arbiter.sv
// rtl/oled_i2c_arbiter.sv - two-port packet arbiter in front of the shared i2c_master byte engine
//
// Purpose: grants the byte engine to port 0 (init/command sequencer) or
//          port 1 (frame streamer) and wraps each packet as START, address
//          byte, control byte, payload, STOP. Reports done/err per port.
// Config:  OLED_ARB_RR_EN defined -> round-robin on ties; undefined ->
//          fixed priority, port 0 wins ties.
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   rqN_tvalid/tdata/tlast  payload stream from requester N
//   rqN_tready              payload byte consumed this cycle
//   rqN_done / rqN_err      1-cycle packet completion / failure pulses
//   mst_req/data/first/last byte request to i2c_master
//   mst_abort               1-cycle pulse: master drops byte, issues STOP
//   mst_ack / mst_nack      byte outcome pulses from i2c_master
//   busy / owner            arbiter active / granted port
module oled_i2c_arbiter
   import oled_i2c_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR = OLED_ADDR,
   parameter logic [7:0] CTRL_CMD   = OLED_CTRL_CMD,
   parameter logic [7:0] CTRL_DATA  = OLED_CTRL_DATA,
   parameter int         WDOG_CYC   = OLED_WDOG_CYC
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rq0_tvalid,
   input  logic [7:0] rq0_tdata,
   input  logic       rq0_tlast,
   output logic       rq0_tready,
   output logic       rq0_done,
   output logic       rq0_err,
   input  logic       rq1_tvalid,
   input  logic [7:0] rq1_tdata,
   input  logic       rq1_tlast,
   output logic       rq1_tready,
   output logic       rq1_done,
   output logic       rq1_err,
   output logic       mst_req,
   output logic [7:0] mst_data,
   output logic       mst_first,
   output logic       mst_last,
   output logic       mst_abort,
   input  logic       mst_ack,
   input  logic       mst_nack,
   output logic       busy,
   output logic       owner
);

   arb_state_t state, state_next;
   logic       owner_q, owner_next, grant;
   logic       sel_tvalid, sel_tlast;
   logic [7:0] sel_tdata;
   mst_cmd_t   cmd;
   logic       req_now, rdy, done_p, err_p;
   logic       wd_clear, wd_expire, timeout;

`ifdef OLED_ARB_RR_EN
   logic       last_served;
`endif

   // Granted port's stream, muxed once for the whole FSM.
   assign sel_tvalid = owner_q ? rq1_tvalid : rq0_tvalid;
   assign sel_tdata  = owner_q ? rq1_tdata  : rq0_tdata;
   assign sel_tlast  = owner_q ? rq1_tlast  : rq0_tlast;

   // Request level is computed outside the FSM block so the watchdog
   // enable does not depend on the block that consumes its expire.
   assign req_now = (state == ST_ADDR) || (state == ST_CTRL) ||
                    ((state == ST_DATA) && sel_tvalid);

   // ack/nack arriving on the expiry cycle wins over the timeout.
   assign timeout  = wd_expire && !mst_ack && !mst_nack;
   assign wd_clear = (state_next != state) || mst_ack || mst_nack;

   oled_i2c_wdog #(.WDOG_CYC(WDOG_CYC)) u_wdog (
      .clk    (clk),
      .reset  (reset),
      .clear  (wd_clear),
      .enable (req_now),
      .expire (wd_expire)
   );

   always_comb begin
      grant = 1'b0;
`ifdef OLED_ARB_RR_EN
      if (rq0_tvalid && rq1_tvalid) begin
         grant = ~last_served;
      end else begin
         grant = rq1_tvalid;
      end
`else
      grant = ~rq0_tvalid;
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= ST_IDLE;
         owner_q <= 1'b0;
      end else begin
         state   <= state_next;
         owner_q <= owner_next;
      end
   end

`ifdef OLED_ARB_RR_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_served <= 1'b0;
      end else if (done_p || err_p) begin
         last_served <= owner_q;
      end
   end
`endif

   always_comb begin
      state_next = state;
      owner_next = owner_q;
      cmd        = MST_IDLE;
      rdy        = 1'b0;
      done_p     = 1'b0;
      err_p      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (rq0_tvalid || rq1_tvalid) begin
               owner_next = grant;
               state_next = ST_ADDR;
            end
         end
         ST_ADDR: begin
            cmd.req   = 1'b1;
            cmd.data  = addr_byte(SLAVE_ADDR, 1'b0);
            cmd.first = 1'b1;
            if (mst_ack) begin
               state_next = ST_CTRL;
            end else if (mst_nack || timeout) begin
               state_next = ST_DRAIN;
            end
         end
         ST_CTRL: begin
            cmd.req  = 1'b1;
            cmd.data = owner_q ? CTRL_DATA : CTRL_CMD;
            if (mst_ack) begin
               state_next = ST_DATA;
            end else if (mst_nack || timeout) begin
               state_next = ST_DRAIN;
            end
         end
         ST_DATA: begin
            // A stalled requester drops mst_req; the master keeps SCL low.
            cmd.req  = sel_tvalid;
            cmd.data = sel_tdata;
            cmd.last = sel_tlast;
            if (mst_ack) begin
               rdy = 1'b1;
               if (sel_tlast) begin
                  state_next = ST_FIN;
               end
            end else if (mst_nack || timeout) begin
               // The refused byte stays with the requester and is drained.
               state_next = ST_DRAIN;
            end
         end
         ST_FIN: begin
            done_p     = 1'b1;
            state_next = ST_IDLE;
         end
         ST_DRAIN: begin
            rdy = 1'b1;
            if (sel_tvalid && sel_tlast) begin
               err_p      = 1'b1;
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign mst_req    = cmd.req;
   assign mst_data   = cmd.data;
   assign mst_first  = cmd.first;
   assign mst_last   = cmd.last;
   assign mst_abort  = timeout;

   assign rq0_tready = rdy    && !owner_q;
   assign rq1_tready = rdy    &&  owner_q;
   assign rq0_done   = done_p && !owner_q;
   assign rq1_done   = done_p &&  owner_q;
   assign rq0_err    = err_p  && !owner_q;
   assign rq1_err    = err_p  &&  owner_q;

   assign busy       = (state != ST_IDLE);
   assign owner      = owner_q;

endmodule

// File: tb/tb_oled_i2c_arbiter.sv
// tb/tb_oled_i2c_arbiter.sv - directed self-checking bench for oled_i2c_arbiter
module tb_oled_i2c_arbiter;

   logic       clk = 1'b0;
   logic       reset;
   logic       rq0_tvalid, rq0_tlast, rq0_tready, rq0_done, rq0_err;
   logic [7:0] rq0_tdata;
   logic       rq1_tvalid, rq1_tlast, rq1_tready, rq1_done, rq1_err;
   logic [7:0] rq1_tdata;
   logic       mst_req, mst_first, mst_last, mst_abort, mst_ack, mst_nack, busy, owner;
   logic [7:0] mst_data;

   int checks   = 0;
   int failures = 0;

   logic [8:0] q0[$];
   logic [8:0] q1[$];
   logic [9:0] log_q[$];
   logic [8:0] tmp;

   int byte_idx, nack_byte, req_run, abort_at;
   bit silent;
   int rdy0, rdy1, rdy1_noack, done0, done1, err0, err1, aborts, both_rdy;

   oled_i2c_arbiter #(.WDOG_CYC(50)) dut (
      .clk        (clk),
      .reset      (reset),
      .rq0_tvalid (rq0_tvalid),
      .rq0_tdata  (rq0_tdata),
      .rq0_tlast  (rq0_tlast),
      .rq0_tready (rq0_tready),
      .rq0_done   (rq0_done),
      .rq0_err    (rq0_err),
      .rq1_tvalid (rq1_tvalid),
      .rq1_tdata  (rq1_tdata),
      .rq1_tlast  (rq1_tlast),
      .rq1_tready (rq1_tready),
      .rq1_done   (rq1_done),
      .rq1_err    (rq1_err),
      .mst_req    (mst_req),
      .mst_data   (mst_data),
      .mst_first  (mst_first),
      .mst_last   (mst_last),
      .mst_abort  (mst_abort),
      .mst_ack    (mst_ack),
      .mst_nack   (mst_nack),
      .busy       (busy),
      .owner      (owner)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation still running, required finish");
      $fatal(1);
   end

   function automatic logic [19:0] all_outs();
      return {rq0_tready, rq0_done, rq0_err, rq1_tready, rq1_done, rq1_err,
              mst_req, mst_data, mst_first, mst_last, mst_abort, busy, owner};
   endfunction

   task automatic clear_stats();
      log_q.delete();
      byte_idx = 0; nack_byte = -1; req_run = 0; abort_at = -1; silent = 0;
      rdy0 = 0; rdy1 = 0; rdy1_noack = 0; done0 = 0; done1 = 0;
      err0 = 0; err1 = 0; aborts = 0; both_rdy = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      q0.delete(); q1.delete();
      rq0_tvalid = 0; rq0_tdata = 0; rq0_tlast = 0;
      rq1_tvalid = 0; rq1_tdata = 0; rq1_tlast = 0;
      mst_ack = 0; mst_nack = 0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      clear_stats();
   endtask

   // One clock of requesters plus slave/master model: the model answers a
   // request on its second waiting cycle unless told to stay silent.
   task automatic cycle();
      @(negedge clk);
      mst_ack = 0; mst_nack = 0;
      rq0_tvalid = (q0.size() != 0);
      rq0_tdata  = rq0_tvalid ? q0[0][7:0] : 8'h00;
      rq0_tlast  = rq0_tvalid ? q0[0][8]   : 1'b0;
      rq1_tvalid = (q1.size() != 0);
      rq1_tdata  = rq1_tvalid ? q1[0][7:0] : 8'h00;
      rq1_tlast  = rq1_tvalid ? q1[0][8]   : 1'b0;
      #1;
      if (mst_req) begin
         req_run++;
         if (!silent && req_run >= 2) begin
            if (byte_idx == nack_byte) mst_nack = 1'b1;
            else mst_ack = 1'b1;
            byte_idx++;
         end
      end else begin
         req_run = 0;
      end
      #1;
      if (mst_ack) log_q.push_back({mst_first, mst_last, mst_data});
      if (mst_abort) begin aborts++; abort_at = req_run; end
      if (rq0_tready) begin rdy0++; if (q0.size() != 0) tmp = q0.pop_front(); end
      if (rq1_tready) begin rdy1++; if (q1.size() != 0) tmp = q1.pop_front(); end
      if (rq1_tready && !mst_ack) rdy1_noack++;
      if (rq0_tready && rq1_tready) both_rdy++;
      if (rq0_done) done0++;
      if (rq1_done) done1++;
      if (rq0_err) err0++;
      if (rq1_err) err1++;
      if (mst_ack || mst_nack) req_run = 0;
   endtask

   task automatic run_idle(input int max, input string name);
      int n;
      n = 0;
      do begin
         cycle();
         n++;
      end while (!(n >= 3 && !busy && q0.size() == 0 && q1.size() == 0) && n < max);
      checks++;
      if (n >= max) begin
         failures++;
         $display("FAIL %s_idle: busy=%0b q0=%0d q1=%0d after %0d cycles, required idle",
                  name, busy, q0.size(), q1.size(), n);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      rq0_tvalid = 0; rq0_tdata = 0; rq0_tlast = 0;
      rq1_tvalid = 0; rq1_tdata = 0; rq1_tlast = 0;
      mst_ack = 0; mst_nack = 0;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (all_outs() !== 20'h0) begin
         failures++;
         $display("FAIL reset_outputs: got %h required 00000", all_outs());
      end
      reset = 1'b0;
      clear_stats();
   endtask

   task automatic test_rq0_cmd();
      logic [9:0] exp_a [5];
      exp_a = '{10'h278, 10'h000, 10'h0AE, 10'h0D5, 10'h180};
      do_reset();
      q0.push_back(9'h0AE); q0.push_back(9'h0D5); q0.push_back(9'h180);
      run_idle(200, "rq0");
      checks++;
      if (log_q.size() !== 5) begin
         failures++; $display("FAIL rq0_nbytes: got %0d required 5", log_q.size());
      end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (((i < log_q.size()) ? log_q[i] : 10'h3FF) !== exp_a[i]) begin
            failures++;
            $display("FAIL rq0_byte%0d: got %h required %h", i,
                     (i < log_q.size()) ? log_q[i] : 10'h3FF, exp_a[i]);
         end
      end
      checks++;
      if (done0 !== 1 || err0 !== 0 || rdy0 !== 3) begin
         failures++;
         $display("FAIL rq0_status: done=%0d err=%0d tready=%0d required 1 0 3", done0, err0, rdy0);
      end
   endtask

   task automatic test_rq1_data();
      logic [9:0] exp_a [4];
      exp_a = '{10'h278, 10'h040, 10'h012, 10'h134};
      do_reset();
      q1.push_back(9'h012); q1.push_back(9'h134);
      run_idle(200, "rq1");
      checks++;
      if (log_q.size() !== 4) begin
         failures++; $display("FAIL rq1_nbytes: got %0d required 4", log_q.size());
      end
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (((i < log_q.size()) ? log_q[i] : 10'h3FF) !== exp_a[i]) begin
            failures++;
            $display("FAIL rq1_byte%0d: got %h required %h", i,
                     (i < log_q.size()) ? log_q[i] : 10'h3FF, exp_a[i]);
         end
      end
      checks++;
      if (rdy1 !== 2 || rdy1_noack !== 0 || done1 !== 1 || both_rdy !== 0 || rdy0 !== 0) begin
         failures++;
         $display("FAIL rq1_status: tready=%0d unaligned=%0d done=%0d both=%0d rdy0=%0d required 2 0 1 0 0",
                  rdy1, rdy1_noack, done1, both_rdy, rdy0);
      end
   endtask

   task automatic test_tie();
      logic [9:0] exp_a [6];
`ifdef OLED_ARB_RR_EN
      exp_a = '{10'h278, 10'h040, 10'h1BB, 10'h278, 10'h000, 10'h1AA};
`else
      exp_a = '{10'h278, 10'h000, 10'h1AA, 10'h278, 10'h040, 10'h1BB};
`endif
      do_reset();
      q0.push_back(9'h1AA); q1.push_back(9'h1BB);
      run_idle(300, "tie");
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (((i < log_q.size()) ? log_q[i] : 10'h3FF) !== exp_a[i]) begin
            failures++;
            $display("FAIL tie_byte%0d: got %h required %h", i,
                     (i < log_q.size()) ? log_q[i] : 10'h3FF, exp_a[i]);
         end
      end
      checks++;
      if (done0 !== 1 || done1 !== 1 || both_rdy !== 0) begin
         failures++;
         $display("FAIL tie_status: done0=%0d done1=%0d both=%0d required 1 1 0", done0, done1, both_rdy);
      end
   endtask

   task automatic test_nack_addr();
      do_reset();
      nack_byte = 0;
      q1.push_back(9'h011); q1.push_back(9'h022); q1.push_back(9'h033); q1.push_back(9'h144);
      run_idle(200, "nack");
      checks++;
      if (rdy1 !== 4 || err1 !== 1 || done1 !== 0 || rdy0 !== 0 || log_q.size() !== 0) begin
         failures++;
         $display("FAIL nack_status: tready=%0d err=%0d done=%0d rdy0=%0d acked=%0d required 4 1 0 0 0",
                  rdy1, err1, done1, rdy0, log_q.size());
      end
      checks++;
      if (busy !== 1'b0) begin
         failures++; $display("FAIL nack_busy: got %0b required 0", busy);
      end
   endtask

   task automatic test_wdog();
      do_reset();
      silent = 1;
      q0.push_back(9'h001); q0.push_back(9'h102);
      run_idle(200, "wdog");
      checks++;
      if (aborts !== 1 || abort_at !== 50) begin
         failures++;
         $display("FAIL wdog_abort: pulses=%0d at_wait=%0d required 1 at 50", aborts, abort_at);
      end
      checks++;
      if (err0 !== 1 || done0 !== 0 || rdy0 !== 2) begin
         failures++;
         $display("FAIL wdog_drain: err=%0d done=%0d tready=%0d required 1 0 2", err0, done0, rdy0);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      do_reset();
      q0.push_back(9'h0AE); q0.push_back(9'h0D5); q0.push_back(9'h180);
      n = 0;
      while (log_q.size() < 3 && n < 100) begin cycle(); n++; end
      @(negedge clk);
      mst_ack = 0; mst_nack = 0;
      rq0_tvalid = (q0.size() != 0);
      rq0_tdata  = rq0_tvalid ? q0[0][7:0] : 8'h00;
      rq0_tlast  = rq0_tvalid ? q0[0][8]   : 1'b0;
      #1;
      checks++;
      if (mst_req !== 1'b1 || mst_data !== 8'hD5) begin
         failures++;
         $display("FAIL mid_pre: req=%0b data=%h required 1 d5", mst_req, mst_data);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (all_outs() !== 20'h0) begin
         failures++;
         $display("FAIL mid_reset_outputs: got %h required 00000", all_outs());
      end
      @(negedge clk);
      q0.delete();
      rq0_tvalid = 0; rq0_tdata = 0; rq0_tlast = 0;
      reset = 1'b0;
      clear_stats();
      q0.push_back(9'h15A);
      run_idle(200, "after_reset");
      checks++;
      if (log_q.size() !== 3 || done0 !== 1 || err0 !== 0) begin
         failures++;
         $display("FAIL after_reset_pkt: bytes=%0d done=%0d err=%0d required 3 1 0",
                  log_q.size(), done0, err0);
      end
      checks++;
      if (((log_q.size() == 3) ? log_q[2] : 10'h3FF) !== 10'h15A) begin
         failures++;
         $display("FAIL after_reset_byte: got %h required 15a",
                  (log_q.size() == 3) ? log_q[2] : 10'h3FF);
      end
   endtask

   initial begin
      test_reset();
      test_rq0_cmd();
      test_rq1_data();
      test_tie();
      test_nack_addr();
      test_wdog();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
